// File: rtl/led_status_pkg.sv
// Shared mode encoding and decode helper for the front-panel LED status driver.
package led_status_pkg;

    // Per-channel display mode, two bits per channel on the mode bus
    typedef enum logic [1:0] {
        LED_OFF  = 2'b00,
        LED_ON   = 2'b01,
        LED_SLOW = 2'b10,
        LED_FAST = 2'b11
    } led_mode_t;

    // Returns 1 when a channel in mode m should be lit, given the shared blink phases
    function automatic logic mode_lit(led_mode_t m, logic slow_ph, logic fast_ph);
        logic lit;
        lit = 1'b0;
        case (m)
            LED_OFF:  lit = 1'b0;
            LED_ON:   lit = 1'b1;
            LED_SLOW: lit = slow_ph;
            LED_FAST: lit = fast_ph;
            default:  lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Shared 1 ms prescaler plus slow and fast blink phase dividers.
// One instance feeds every channel so blinking channels stay in lock-step.
module led_tick_gen #(
    parameter int TICK_DIV = 125000,
    parameter int SLOW_MS  = 500,
    parameter int FAST_MS  = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic slow_ph,
    output logic fast_ph
);

    localparam int PRE_W  = $clog2(TICK_DIV - 1) + 1;
    localparam int SLOW_W = $clog2(SLOW_MS - 1) + 1;
    localparam int FAST_W = $clog2(FAST_MS - 1) + 1;

    localparam logic [PRE_W-1:0]  PRE_TOP  = PRE_W'(TICK_DIV - 1);
    localparam logic [SLOW_W-1:0] SLOW_TOP = SLOW_W'(SLOW_MS - 1);
    localparam logic [FAST_W-1:0] FAST_TOP = FAST_W'(FAST_MS - 1);

    logic [PRE_W-1:0]  pre_cnt_p0;
    logic [SLOW_W-1:0] slow_cnt_p0;
    logic [FAST_W-1:0] fast_cnt_p0;

    // Tick is decoded from the terminal prescaler count, so it is high for exactly one clk
    assign tick = (pre_cnt_p0 == PRE_TOP);

    // Prescaler: free-running 0..TICK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pre_cnt_p0 <= '0;
        else if (tick) pre_cnt_p0 <= '0;
        else           pre_cnt_p0 <= pre_cnt_p0 + 1'b1;
    end

    // Slow phase divider: toggles after every SLOW_MS ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slow_cnt_p0 <= '0;
            slow_ph     <= 1'b0;
        end else if (tick) begin
            if (slow_cnt_p0 == SLOW_TOP) begin
                slow_cnt_p0 <= '0;
                slow_ph     <= ~slow_ph;
            end else begin
                slow_cnt_p0 <= slow_cnt_p0 + 1'b1;
            end
        end
    end

    // Fast phase divider: toggles after every FAST_MS ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fast_cnt_p0 <= '0;
            fast_ph     <= 1'b0;
        end else if (tick) begin
            if (fast_cnt_p0 == FAST_TOP) begin
                fast_cnt_p0 <= '0;
                fast_ph     <= ~fast_ph;
            end else begin
                fast_cnt_p0 <= fast_cnt_p0 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_status_driver.sv
// Front-panel LED status driver: per-channel mode decode, activity stretch
// and sticky fault indication, all timed from one shared tick generator.
module led_status_driver
    import led_status_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 125000,
    parameter int SLOW_MS    = 500,
    parameter int FAST_MS    = 100,
    parameter int STRETCH_MS = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     evt,
    input  logic [N_CH-1:0]     fault_set,
    input  logic [N_CH-1:0]     fault_clr,
    output logic [N_CH-1:0]     led_n,
    output logic [N_CH-1:0]     fault_sticky
);

    localparam int STR_W = $clog2(STRETCH_MS) + 1;
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_MS);

    // Saturating decrement: the stretch counter parks at zero instead of wrapping
    function automatic logic [STR_W-1:0] sat_dec(logic [STR_W-1:0] v);
        logic [STR_W-1:0] r;
        r = v;
        if (v != '0) r = v - 1'b1;
        return r;
    endfunction

    logic tick;
    logic slow_ph;
    logic fast_ph;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .SLOW_MS  (SLOW_MS),
        .FAST_MS  (FAST_MS)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .slow_ph (slow_ph),
        .fast_ph (fast_ph)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [STR_W-1:0] str_cnt_p0;
        logic             fault_p0;
        logic             led_n_p1;
        logic             lit;
        led_mode_t        ch_mode;

        assign ch_mode = led_mode_t'(mode[2*i +: 2]);

        // Activity stretch: an event (re)loads, a tick counts down; a load beats a same-cycle tick
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         str_cnt_p0 <= '0;
            else if (evt[i]) str_cnt_p0 <= STR_LOAD;
            else if (tick)   str_cnt_p0 <= sat_dec(str_cnt_p0);
        end

        // Sticky fault flag: set has priority over clear
        always_ff @(posedge clk or posedge rst) begin
            if (rst)               fault_p0 <= 1'b0;
            else if (fault_set[i]) fault_p0 <= 1'b1;
            else if (fault_clr[i]) fault_p0 <= 1'b0;
        end

        // Display priority: fault blink, then stretch, then the programmed mode
        always_comb begin
            lit = mode_lit(ch_mode, slow_ph, fast_ph);
            if (fault_p0)                lit = fast_ph;
            else if (str_cnt_p0 != '0)   lit = 1'b1;
        end

        // Registered active-low LED drive, dark while in reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) led_n_p1 <= 1'b1;
            else     led_n_p1 <= ~lit;
        end

        assign led_n[i]        = led_n_p1;
        assign fault_sticky[i] = fault_p0;
    end

endmodule

// File: tb/tb_led_status_driver.sv
// Directed testbench for led_status_driver with short timing parameters.
// ecnt counts rising edges since the last reset release; the first edge with rst=0 is edge 1.
module tb_led_status_driver;

    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 4;
    localparam int SLOW_MS    = 8;
    localparam int FAST_MS    = 2;
    localparam int STRETCH_MS = 3;

    logic                clk;
    logic                rst;
    logic [2*N_CH-1:0]   mode;
    logic [N_CH-1:0]     evt;
    logic [N_CH-1:0]     fault_set;
    logic [N_CH-1:0]     fault_clr;
    logic [N_CH-1:0]     led_n;
    logic [N_CH-1:0]     fault_sticky;

    int n_checks;
    int n_fail;
    int ecnt;

    led_status_driver #(
        .N_CH       (N_CH),
        .TICK_DIV   (TICK_DIV),
        .SLOW_MS    (SLOW_MS),
        .FAST_MS    (FAST_MS),
        .STRETCH_MS (STRETCH_MS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .evt          (evt),
        .fault_set    (fault_set),
        .fault_clr    (fault_clr),
        .led_n        (led_n),
        .fault_sticky (fault_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int target);
        while (ecnt < target) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst  = 1'b0;
        ecnt = 0;
    endtask

    task automatic test_reset();
        mode = '0; evt = '0; fault_set = '0; fault_clr = '0;
        rst = 1'b1;
        #2;
        n_checks++;
        if (led_n !== 4'b1111) begin
            n_fail++; $display("FAIL reset_led_n: got %b expected %b", led_n, 4'b1111);
        end
        n_checks++;
        if (fault_sticky !== 4'b0000) begin
            n_fail++; $display("FAIL reset_fault: got %b expected %b", fault_sticky, 4'b0000);
        end
        do_reset();
        step();
        n_checks++;
        if (led_n !== 4'b1111) begin
            n_fail++; $display("FAIL release_led_n: got %b expected %b", led_n, 4'b1111);
        end
        n_checks++;
        if (fault_sticky !== 4'b0000) begin
            n_fail++; $display("FAIL release_fault: got %b expected %b", fault_sticky, 4'b0000);
        end
    endtask

    task automatic test_mode_on();
        mode[1:0] = 2'b01;
        step();
        n_checks++;
        if (led_n !== 4'b1110) begin
            n_fail++; $display("FAIL mode_on: got %b expected %b", led_n, 4'b1110);
        end
    endtask

    // ch1 slow: dark for edges 1..32, lit 33..64, ... ; ch2 fast: 8-edge runs starting dark
    task automatic test_blink();
        logic [1:0] exp_bits;
        mode = 8'b00_11_10_01;
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            step();
            exp_bits[0] = (((n - 1) / 32) % 2 == 1) ? 1'b0 : 1'b1;
            exp_bits[1] = (((n - 1) / 8) % 2 == 1) ? 1'b0 : 1'b1;
            n_checks++;
            if (led_n[2:1] !== exp_bits) begin
                n_fail++;
                $display("FAIL blink edge %0d: got led_n[2:1]=%b expected %b", n, led_n[2:1], exp_bits);
            end
        end
        n_checks++;
        if (led_n[0] !== 1'b0) begin
            n_fail++; $display("FAIL blink_ch0_on: got %b expected %b", led_n[0], 1'b0);
        end
    endtask

    // Ticks land on edges 4, 8, 12, ... after reset release
    task automatic test_stretch();
        mode = '0; evt = '0;
        do_reset();
        run_to(3);
        evt[3] = 1'b1;
        step();                 // edge 4: load coincides with a tick
        evt[3] = 1'b0;
        n_checks++;
        if (led_n[3] !== 1'b1) begin
            n_fail++; $display("FAIL stretch_e4: got %b expected %b", led_n[3], 1'b1);
        end
        step();
        n_checks++;
        if (led_n[3] !== 1'b0) begin
            n_fail++; $display("FAIL stretch_e5: got %b expected %b", led_n[3], 1'b0);
        end
        run_to(16);
        n_checks++;
        if (led_n[3] !== 1'b0) begin
            n_fail++; $display("FAIL stretch_e16: got %b expected %b", led_n[3], 1'b0);
        end
        step();
        n_checks++;
        if (led_n[3] !== 1'b1) begin
            n_fail++; $display("FAIL stretch_e17: got %b expected %b", led_n[3], 1'b1);
        end
        // Retrigger: load at 20, reload at 27 before expiry, ticks 28/32/36 drain it
        run_to(19);
        evt[3] = 1'b1;
        step();
        evt[3] = 1'b0;
        run_to(26);
        evt[3] = 1'b1;
        step();
        evt[3] = 1'b0;
        run_to(33);
        n_checks++;
        if (led_n[3] !== 1'b0) begin
            n_fail++; $display("FAIL retrigger_e33: got %b expected %b", led_n[3], 1'b0);
        end
        run_to(36);
        n_checks++;
        if (led_n[3] !== 1'b0) begin
            n_fail++; $display("FAIL retrigger_e36: got %b expected %b", led_n[3], 1'b0);
        end
        step();
        n_checks++;
        if (led_n[3] !== 1'b1) begin
            n_fail++; $display("FAIL retrigger_e37: got %b expected %b", led_n[3], 1'b1);
        end
    endtask

    task automatic test_fault();
        mode = 8'b00_00_00_01; evt = '0; fault_set = '0; fault_clr = '0;
        do_reset();
        run_to(1);
        fault_set[0] = 1'b1;
        fault_clr[0] = 1'b1;
        step();                 // edge 2
        fault_set[0] = 1'b0;
        fault_clr[0] = 1'b0;
        n_checks++;
        if (fault_sticky !== 4'b0001) begin
            n_fail++; $display("FAIL fault_set_wins: got %b expected %b", fault_sticky, 4'b0001);
        end
        n_checks++;
        if (led_n[0] !== 1'b0) begin
            n_fail++; $display("FAIL fault_e2_led: got %b expected %b", led_n[0], 1'b0);
        end
        step();
        n_checks++;
        if (led_n[0] !== 1'b1) begin
            n_fail++; $display("FAIL fault_e3_led: got %b expected %b", led_n[0], 1'b1);
        end
        run_to(9);
        n_checks++;
        if (led_n[0] !== 1'b0) begin
            n_fail++; $display("FAIL fault_e9_led: got %b expected %b", led_n[0], 1'b0);
        end
        run_to(17);
        n_checks++;
        if (led_n[0] !== 1'b1) begin
            n_fail++; $display("FAIL fault_e17_led: got %b expected %b", led_n[0], 1'b1);
        end
        n_checks++;
        if (fault_sticky !== 4'b0001) begin
            n_fail++; $display("FAIL fault_sticky_hold: got %b expected %b", fault_sticky, 4'b0001);
        end
        run_to(19);
        fault_clr[0] = 1'b1;
        step();                 // edge 20
        fault_clr[0] = 1'b0;
        n_checks++;
        if (fault_sticky !== 4'b0000) begin
            n_fail++; $display("FAIL fault_clear: got %b expected %b", fault_sticky, 4'b0000);
        end
        n_checks++;
        if (led_n[0] !== 1'b1) begin
            n_fail++; $display("FAIL fault_e20_led: got %b expected %b", led_n[0], 1'b1);
        end
        step();
        n_checks++;
        if (led_n[0] !== 1'b0) begin
            n_fail++; $display("FAIL fault_e21_led: got %b expected %b", led_n[0], 1'b0);
        end
    endtask

    task automatic test_reset_mid_stretch();
        mode = 8'b00_11_00_01; evt = '0; fault_set = '0; fault_clr = '0;
        do_reset();
        run_to(1);
        evt[3]       = 1'b1;
        fault_set[1] = 1'b1;
        step();
        evt[3]       = 1'b0;
        fault_set[1] = 1'b0;
        step();
        n_checks++;
        if (led_n[3] !== 1'b0 || fault_sticky[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got led_n[3]=%b fault[1]=%b expected 0 1", led_n[3], fault_sticky[1]);
        end
        run_to(5);
        rst = 1'b1;
        #1;
        n_checks++;
        if (led_n !== 4'b1111) begin
            n_fail++; $display("FAIL async_reset_led_n: got %b expected %b", led_n, 4'b1111);
        end
        n_checks++;
        if (fault_sticky !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset_fault: got %b expected %b", fault_sticky, 4'b0000);
        end
        do_reset();
        for (int n = 1; n <= 14; n++) begin
            step();
            n_checks++;
            if (led_n[3] !== 1'b1) begin
                n_fail++; $display("FAIL residual_stretch edge %0d: got %b expected %b", n, led_n[3], 1'b1);
            end
            if (n == 8 || n == 9) begin
                n_checks++;
                if (led_n[2] !== ((n == 9) ? 1'b0 : 1'b1)) begin
                    n_fail++;
                    $display("FAIL restart_fast edge %0d: got %b expected %b", n, led_n[2], (n == 9) ? 1'b0 : 1'b1);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ecnt     = 0;
        rst      = 1'b1;
        mode     = '0;
        evt      = '0;
        fault_set = '0;
        fault_clr = '0;
        test_reset();
        test_mode_on();
        test_blink();
        test_stretch();
        test_fault();
        test_reset_mid_stretch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_status_driver.md
LED_STATUS_DRIVER -- requirements
Module: led_status_driver

Interface
REQ-001 Parameter N_CH, default 4: number of front-panel LED channels, 1..16.
REQ-002 Parameter TICK_DIV, default 125000: clk cycles per 1 ms tick, >=2.
REQ-003 Parameter SLOW_MS, default 500: slow-blink half-period in ticks, >=1.
REQ-004 Parameter FAST_MS, default 100: fast-blink half-period in ticks, >=1.
REQ-005 Parameter STRETCH_MS, default 50: event stretch length in ticks, >=1.
REQ-006 Port clk  in  1  single system clock; all logic on its rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-high.
REQ-008 Port mode  in  2*N_CH  per-channel mode, channel i at [2i+1:2i]; 00 off, 01 on, 10 slow blink, 11 fast blink.
REQ-009 Port event  in  N_CH  per-channel activity pulse, sampled every clk.
REQ-010 Port fault_set  in  N_CH  per-channel fault request, sampled every clk.
REQ-011 Port fault_clr  in  N_CH  per-channel sticky-fault clear, sampled every clk.
REQ-012 Port led_n  out  N_CH  LED drive, active low (0 = lit, 1 = dark), registered.
REQ-013 Port fault_sticky  out  N_CH  current sticky-fault flags, registered.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 and wraps; tick asserts for exactly one clk when count = TICK_DIV-1.
REQ-015 Slow phase toggles after every SLOW_MS ticks, fast phase after every FAST_MS ticks; both reset to 0; LED lit while phase = 1.
REQ-016 Phases and prescaler are shared by all channels, so blinking channels in the same mode stay in lock-step.
REQ-017 Per channel, event=1 loads the stretch counter with STRETCH_MS (a retrigger reloads it); each tick decrements it when nonzero; stretch is active while the counter is nonzero.
REQ-018 Event and tick in the same cycle: the load wins and no decrement occurs that cycle.
REQ-019 fault_set=1 sets the sticky flag; fault_clr=1 clears it; both in the same cycle: set wins.
REQ-020 Display priority per channel: sticky fault shows fast-phase blink, else active stretch shows lit, else mode as decoded.
REQ-021 led_n and fault_sticky update on the clk edge after the causing input or state change (latency 1 clk).
REQ-022 Counter widths are $clog2 of their maximum value plus 1; no counter overflows or wraps except the prescaler and the phase dividers.

Reset
REQ-023 While rst=1: led_n all ones, fault_sticky all zeros, prescaler, divider and stretch counters 0, both phases 0, independent of clk.
REQ-024 Reset asserted mid-stretch or mid-blink discards that state; after release, behaviour restarts as from power-up.
REQ-025 The first tick after reset release occurs TICK_DIV clk cycles after the first clk edge with rst=0.

Structure
REQ-026 Package led_status_pkg holds the mode encoding constants (LED_OFF, LED_ON, LED_SLOW, LED_FAST) and the led_mode_t 2-bit typedef.
REQ-027 Sub-module led_tick_gen holds the prescaler and both phase dividers and outputs tick, slow_ph and fast_ph.
REQ-028 Per-channel stretch, fault and display logic is replicated with a generate loop over N_CH in led_status_driver.

Verification (TICK_DIV=4, SLOW_MS=8, FAST_MS=2, STRETCH_MS=3, N_CH=4)
REQ-029 Assert rst, then release with mode=0 -> led_n=4'b1111 and fault_sticky=0; set mode ch0=01 -> led_n[0]=0 one clk later.
REQ-030 ch1 mode=10 from reset -> led_n[1] dark for 32 clk, then alternately lit and dark in 32-clk runs; ch2 mode=11 -> 8-clk runs, aligned with ch1 edges.
REQ-031 ch3 mode=00, one-cycle event -> led_n[3] lit for 9..12 clk, depending on prescaler phase; a second event before expiry -> lit for 9..12 clk after the second event.
REQ-032 ch0 fault_set and fault_clr in the same cycle -> fault_sticky[0]=1 and led_n[0] fast-blinks; later fault_clr alone -> flag 0 and led_n[0] follows mode again next clk.
REQ-033 rst pulse asserted mid-stretch on ch3 -> led_n[3]=1 immediately (asynchronous); after release no residual stretch until a new event.
